bypass_select_tracker: RTL
==========================

BYPASS_SELECT_TRACKER -- requirements
Module: bypass_select_tracker

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning producer/consumer lanes in one issue group.
REQ-002 SHALL have parameter PREG_W, default 7, meaning physical register number width.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state is clocked on the rising edge.
REQ-004 SHALL have port rst  in  1  meaning synchronous, active-low reset.
REQ-005 SHALL have port stall  in  1  meaning hold all state.
REQ-006 SHALL have port flush  in  1  meaning kill all in-flight entries.
REQ-007 SHALL have port rrValid  in  LANES  meaning register-read (RR) stage lane occupied.
REQ-008 SHALL have ports srcNumA and srcNumB  in  LANES x PREG_W  meaning consumer physical sources.
REQ-009 SHALL have ports readA and readB  in  LANES  meaning the matching source is actually read.
REQ-010 SHALL have ports dstNum  in  LANES x PREG_W and writeReg  in  LANES  meaning the producer destination and its write flag.
REQ-011 SHALL have ports selStageA and selStageB  out  LANES x 2  meaning the bypass source stage: 0 NONE, 1 D1, 2 D2, 3 reserved.
REQ-012 SHALL have ports selLaneA and selLaneB  out  LANES x clog2(LANES)  meaning the producing lane.

Function
REQ-013 SHALL keep two history slots per lane: D1 (instruction in EX) and D2 (instruction in WB), each holding {valid, dstNum}.
REQ-014 SHALL, on a non-stall cycle, load D1 valid with rrValid & writeReg and load D1 dstNum with dstNum.
REQ-015 SHALL, on a non-stall cycle, copy D1 into D2.
REQ-016 SHALL compute each consumer lane's source A by comparing srcNumA with every valid D1 and D2 entry, and source B the same way.
REQ-017 SHALL give D1 matches priority over D2 matches (youngest producer wins).
REQ-018 SHALL, within one stage, select the lowest matching lane index.
REQ-019 SHALL force sel to NONE when readX=0 or rrValid=0, regardless of matches.
REQ-020 SHALL never match a source against other lanes of the same RR group.
REQ-021 SHALL register the sel outputs, so they are valid one cycle after RR, aligned to EX.
REQ-022 SHALL hold D1, D2 and the sel outputs unchanged while stall=1.
REQ-023 SHALL, on flush=1, clear all D1/D2 valids and set all sel outputs to NONE/lane 0 at the next edge; flush overrides stall.
REQ-024 SHALL, on flush and a new RR group in the same cycle, discard the new group.
REQ-025 SHALL, for a lane whose match is invalid (valid=0), not select that lane even when the register number is equal.

Reset
REQ-026 SHALL, while rst=0 at a clock edge, clear all D1/D2 valids, set sel stage outputs to 0 (NONE) and set sel lane outputs to 0.
REQ-027 SHALL, on reset mid-operation, drop all history; the first group after reset sees no bypass.
REQ-028 SHALL give reset priority over flush and stall.

Structure
REQ-029 SHALL place the 2-bit stage encoding typedef (NONE/D1/D2) and the LANES and PREG_W defaults in the shared bypass types package.
REQ-030 SHALL implement a single sub-module, bypass_match_select, as a combinational per-source priority matcher returning {stage, lane}; it is instantiated 2*LANES times.

Verification
REQ-031 SHALL cover: lane0 writes p5 at t; lane1 reads A=p5 at t+1 -> at t+2 selStageA[1]=D1, selLaneA[1]=0.
REQ-032 SHALL cover: producer p9 at t, unrelated group at t+1, consumer reads B=p9 at t+2 -> at t+3 selStageB=D2.
REQ-033 SHALL cover: p3 written at t (lane1) and t+1 (lane0), consumer reads p3 at t+2 -> D1, lane0 (youngest wins).
REQ-034 SHALL cover: match present but readA=0 -> selStageA=NONE.
REQ-035 SHALL cover: stall held for 3 cycles -> outputs and history frozen; after release, the D1 match is still produced.
REQ-036 SHALL cover: flush or rst=0 with p7 in D1, then a consumer reads p7 -> NONE.

Source files
------------

// File: rtl/bypass_select_tracker_pkg.sv
// ---------------------------------------------------------------------------
// bypass_select_tracker_pkg
//
// Shared bypass types for the bypass select tracker and its matcher.
//   - bypassStage_e : 2-bit encoding of where a bypass operand comes from
//   - BYP_LANES     : default number of lanes in one issue group
//   - BYP_PREG_W    : default physical register number width
// ---------------------------------------------------------------------------
package bypass_select_tracker_pkg;

    localparam int BYP_LANES  = 2;
    localparam int BYP_PREG_W = 7;

    // Bypass source stage. STAGE_RSVD is never produced by the tracker.
    typedef enum logic [1:0] {
        STAGE_NONE = 2'd0,
        STAGE_D1   = 2'd1,
        STAGE_D2   = 2'd2,
        STAGE_RSVD = 2'd3
    } bypassStage_e;

endpackage : bypass_select_tracker_pkg

// File: rtl/bypass_match_select.sv
// ---------------------------------------------------------------------------
// bypass_match_select
//
// Combinational priority matcher for one consumer source operand. It compares
// the source register number against every valid D1 (EX) and D2 (WB) history
// entry and returns where the youngest matching producer lives.
//
// Ports
//   enable  in  1               source is really read by an occupied RR lane
//   srcNum  in  PREG_W          consumer physical source register
//   d1Valid in  LANES           D1 history valids
//   d1Dst   in  LANES x PREG_W  D1 history destination registers
//   d2Valid in  LANES           D2 history valids
//   d2Dst   in  LANES x PREG_W  D2 history destination registers
//   stage   out 2               STAGE_NONE / STAGE_D1 / STAGE_D2
//   lane    out LANE_W          producing lane (0 when stage is NONE)
// ---------------------------------------------------------------------------
module bypass_match_select
    import bypass_select_tracker_pkg::*;
#(
    parameter int LANES  = BYP_LANES,
    parameter int PREG_W = BYP_PREG_W,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic                           enable,
    input  logic [PREG_W-1:0]              srcNum,
    input  logic [LANES-1:0]               d1Valid,
    input  logic [LANES-1:0][PREG_W-1:0]   d1Dst,
    input  logic [LANES-1:0]               d2Valid,
    input  logic [LANES-1:0][PREG_W-1:0]   d2Dst,
    output bypassStage_e                   stage,
    output logic [LANE_W-1:0]              lane
);

    logic [LANES-1:0] d1Hit;
    logic [LANES-1:0] d2Hit;

    // Index of the lowest set bit; scanning downward lets the lowest hit win.
    function automatic logic [LANE_W-1:0] lowestIndex(input logic [LANES-1:0] hits);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                idx = LANE_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Per-lane hit vectors; an invalid entry never hits even if the number matches.
    always_comb begin
        d1Hit = '0;
        d2Hit = '0;
        for (int i = 0; i < LANES; i++) begin
            d1Hit[i] = d1Valid[i] && (d1Dst[i] == srcNum);
            d2Hit[i] = d2Valid[i] && (d2Dst[i] == srcNum);
        end
    end

    // Stage priority: D1 (youngest) over D2, lowest lane within a stage.
    always_comb begin
        stage = STAGE_NONE;
        lane  = '0;
        if (!enable) begin
            stage = STAGE_NONE;
            lane  = '0;
        end else if (|d1Hit) begin
            stage = STAGE_D1;
            lane  = lowestIndex(d1Hit);
        end else if (|d2Hit) begin
            stage = STAGE_D2;
            lane  = lowestIndex(d2Hit);
        end else begin
            stage = STAGE_NONE;
            lane  = '0;
        end
    end

endmodule : bypass_match_select

// File: rtl/bypass_select_tracker.sv
// ---------------------------------------------------------------------------
// bypass_select_tracker
//
// Tracks the destinations of the two issue groups ahead of register read
// (D1 = group now in EX, D2 = group now in WB) and, for every source operand
// of the group in RR, registers which stage/lane should feed it through the
// bypass network. The selects appear one cycle after RR, aligned with EX.
// Sources are never matched against producers of their own RR group.
//
// Ports
//   clk        in  1               rising-edge clock
//   rst        in  1               synchronous active-low reset
//   stall      in  1               hold history and selects
//   flush      in  1               kill history, zero selects, drop RR group
//   rrValid    in  LANES           RR lane occupied
//   srcNumA/B  in  LANES x PREG_W  consumer physical sources
//   readA/B    in  LANES           source actually read
//   dstNum     in  LANES x PREG_W  producer destination
//   writeReg   in  LANES           producer writes dstNum
//   selStageA/B out LANES x 2      0 NONE, 1 D1, 2 D2
//   selLaneA/B  out LANES x clog2(LANES) producing lane
//
// LANES must be at least 2 so the lane select fields are non-empty.
// ---------------------------------------------------------------------------
module bypass_select_tracker
    import bypass_select_tracker_pkg::*;
#(
    parameter int LANES  = BYP_LANES,
    parameter int PREG_W = BYP_PREG_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall,
    input  logic                                  flush,
    input  logic [LANES-1:0]                      rrValid,
    input  logic [LANES-1:0][PREG_W-1:0]          srcNumA,
    input  logic [LANES-1:0][PREG_W-1:0]          srcNumB,
    input  logic [LANES-1:0]                      readA,
    input  logic [LANES-1:0]                      readB,
    input  logic [LANES-1:0][PREG_W-1:0]          dstNum,
    input  logic [LANES-1:0]                      writeReg,
    output logic [LANES-1:0][1:0]                 selStageA,
    output logic [LANES-1:0][1:0]                 selStageB,
    output logic [LANES-1:0][$clog2(LANES)-1:0]   selLaneA,
    output logic [LANES-1:0][$clog2(LANES)-1:0]   selLaneB
);

    localparam int LANE_W = $clog2(LANES);

    // History of the two older groups.
    logic [LANES-1:0]               d1Valid;
    logic [LANES-1:0][PREG_W-1:0]   d1Dst;
    logic [LANES-1:0]               d2Valid;
    logic [LANES-1:0][PREG_W-1:0]   d2Dst;

    // Matcher results for the group currently in RR.
    logic [LANES-1:0][1:0]          nextStageA;
    logic [LANES-1:0][1:0]          nextStageB;
    logic [LANES-1:0][LANE_W-1:0]   nextLaneA;
    logic [LANES-1:0][LANE_W-1:0]   nextLaneB;
    logic [LANES-1:0]               enableA;
    logic [LANES-1:0]               enableB;

    // A source only looks for a producer when its lane is occupied and reads it.
    always_comb begin
        enableA = rrValid & readA;
        enableB = rrValid & readB;
    end

    // One matcher per source operand per lane; none of them sees the RR group's own dstNum.
    for (genvar g = 0; g < LANES; g++) begin : gMatch
        bypass_match_select #(
            .LANES  (LANES),
            .PREG_W (PREG_W),
            .LANE_W (LANE_W)
        ) uMatchA (
            .enable  (enableA[g]),
            .srcNum  (srcNumA[g]),
            .d1Valid (d1Valid),
            .d1Dst   (d1Dst),
            .d2Valid (d2Valid),
            .d2Dst   (d2Dst),
            .stage   (nextStageA[g]),
            .lane    (nextLaneA[g])
        );

        bypass_match_select #(
            .LANES  (LANES),
            .PREG_W (PREG_W),
            .LANE_W (LANE_W)
        ) uMatchB (
            .enable  (enableB[g]),
            .srcNum  (srcNumB[g]),
            .d1Valid (d1Valid),
            .d1Dst   (d1Dst),
            .d2Valid (d2Valid),
            .d2Dst   (d2Dst),
            .stage   (nextStageB[g]),
            .lane    (nextLaneB[g])
        );
    end

    // History shift and select registers; reset beats flush, flush beats stall.
    // A flush also discards the group in RR, since D1 is cleared instead of loaded.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            d1Valid   <= '0;
            d1Dst     <= '0;
            d2Valid   <= '0;
            d2Dst     <= '0;
            selStageA <= '0;
            selStageB <= '0;
            selLaneA  <= '0;
            selLaneB  <= '0;
        end else if (!stall) begin
            d1Valid   <= rrValid & writeReg;
            d1Dst     <= dstNum;
            d2Valid   <= d1Valid;
            d2Dst     <= d1Dst;
            selStageA <= nextStageA;
            selStageB <= nextStageB;
            selLaneA  <= nextLaneA;
            selLaneB  <= nextLaneB;
        end
    end

endmodule : bypass_select_tracker
